// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with full-scan debounce.
// Drives one column low at a time and commits one key per press.
module keypad_scanner #(
    parameter int SCAN_CYCLES    = 100000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] dec,
    output logic       button_pressed,
    output logic       key_strobe
);

    localparam int TW = $clog2(SCAN_CYCLES);
    localparam int SW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [TW-1:0] TICK_LAST  = TW'(SCAN_CYCLES - 1);
    localparam logic [SW-1:0] STABLE_MAX = SW'(DEBOUNCE_SCANS);

    logic [3:0]    row_meta_q;
    logic [3:0]    row_sync_q;
    logic [TW-1:0] tick_q;
    logic [1:0]    col_idx_q;
    logic [3:0]    col_q;
    logic          acc_present_q;
    logic [3:0]    acc_code_q;
    logic          prev_present_q;
    logic [3:0]    prev_code_q;
    logic [SW-1:0] stable_q;
    logic [SW-1:0] stable_d;
    logic          pressed_q;
    logic [3:0]    dec_q;
    logic          strobe_q;

    logic          slot_end;
    logic          scan_end;
    logic          col_hit;
    logic [1:0]    hit_row;
    logic [3:0]    col_code;
    logic          res_present;
    logic [3:0]    res_code;
    logic          same;
    logic          settled;
    logic          commit_press;
    logic          commit_release;

    // Hex code printed on the key at (row r, column c).
    function automatic logic [3:0] key_code(input logic [1:0] r,
                                            input logic [1:0] c);
        logic [3:0] k;
        case ({r, c})
            4'b00_00: k = 4'h1;
            4'b00_01: k = 4'h2;
            4'b00_10: k = 4'h3;
            4'b00_11: k = 4'hA;
            4'b01_00: k = 4'h4;
            4'b01_01: k = 4'h5;
            4'b01_10: k = 4'h6;
            4'b01_11: k = 4'hB;
            4'b10_00: k = 4'h7;
            4'b10_01: k = 4'h8;
            4'b10_10: k = 4'h9;
            4'b10_11: k = 4'hC;
            4'b11_00: k = 4'h0;
            4'b11_01: k = 4'hF;
            4'b11_10: k = 4'hE;
            default:  k = 4'hD;
        endcase
        return k;
    endfunction

    assign slot_end = (tick_q == TICK_LAST);
    assign scan_end = slot_end && (col_idx_q == 2'd3);
    assign col_hit  = (row_sync_q != 4'hF);

    // Lowest-numbered low row in the currently driven column wins.
    always_comb begin
        hit_row = 2'd3;
        if (!row_sync_q[0])      hit_row = 2'd0;
        else if (!row_sync_q[1]) hit_row = 2'd1;
        else if (!row_sync_q[2]) hit_row = 2'd2;
    end

    assign col_code    = key_code(hit_row, col_idx_q);
    assign res_present = acc_present_q | col_hit;
    assign res_code    = acc_present_q ? acc_code_q :
                         (col_hit ? col_code : 4'h0);

    assign same = (res_present == prev_present_q) &&
                  (res_code == prev_code_q);

    // Stable-scan count after this scan result is folded in.
    always_comb begin
        stable_d = SW'(1);
        if (same) begin
            stable_d = (stable_q == STABLE_MAX) ? stable_q
                                                : stable_q + SW'(1);
        end
    end

    assign settled        = (stable_d == STABLE_MAX);
    assign commit_press   = scan_end && settled && res_present && !pressed_q;
    assign commit_release = scan_end && settled && !res_present && pressed_q;

    // Two-flop synchronizer; idle rows read as all-high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_meta_q <= 4'hF;
            row_sync_q <= 4'hF;
        end else begin
            row_meta_q <= row;
            row_sync_q <= row_meta_q;
        end
    end

    // Slot timer and one-cold column rotation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_q    <= '0;
            col_idx_q <= 2'd0;
            col_q     <= 4'b1110;
        end else if (slot_end) begin
            tick_q    <= '0;
            col_idx_q <= col_idx_q + 2'd1;
            col_q     <= {col_q[2:0], col_q[3]};
        end else begin
            tick_q <= tick_q + TW'(1);
        end
    end

    // First hit of the scan in progress, cleared when the scan closes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_present_q <= 1'b0;
            acc_code_q    <= 4'h0;
        end else if (scan_end) begin
            acc_present_q <= 1'b0;
            acc_code_q    <= 4'h0;
        end else if (slot_end && !acc_present_q && col_hit) begin
            acc_present_q <= 1'b1;
            acc_code_q    <= col_code;
        end
    end

    // Scan-to-scan comparison for debounce.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_present_q <= 1'b0;
            prev_code_q    <= 4'h0;
            stable_q       <= '0;
        end else if (scan_end) begin
            prev_present_q <= res_present;
            prev_code_q    <= res_code;
            stable_q       <= stable_d;
        end
    end

    // Committed key state and single-cycle press strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pressed_q <= 1'b0;
            dec_q     <= 4'h0;
            strobe_q  <= 1'b0;
        end else begin
            strobe_q <= commit_press;
            if (commit_press) begin
                pressed_q <= 1'b1;
                dec_q     <= res_code;
            end else if (commit_release) begin
                pressed_q <= 1'b0;
            end
        end
    end

    assign col            = col_q;
    assign dec            = dec_q;
    assign button_pressed = pressed_q;
    assign key_strobe     = strobe_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a behavioural key matrix.
// Small scan/debounce settings: one full scan is 16 clocks.
module tb_keypad_scanner;

    localparam int SC = 4;
    localparam int DB = 2;

    logic            clk   = 1'b0;
    logic            rst_n = 1'b1;
    logic [3:0]      row;
    logic [3:0]      col;
    logic [3:0]      dec;
    logic            bp;
    logic            ks;
    logic [3:0][3:0] keys;

    int cyc;
    int strobes = 0;
    int nchk    = 0;
    int nfail   = 0;
    int s0;

    keypad_scanner #(
        .SCAN_CYCLES   (SC),
        .DEBOUNCE_SCANS(DB)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .row           (row),
        .col           (col),
        .dec           (dec),
        .button_pressed(bp),
        .key_strobe    (ks)
    );

    always #5 clk = ~clk;

    // Key matrix: a pressed key pulls its row low while its column is driven.
    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r][c] && !col[c]) row[r] = 1'b0;
    end

    // Clock edges since reset release.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    // Strobe counter sampled mid-cycle.
    always @(negedge clk) begin
        if (rst_n && ks) strobes = strobes + 1;
    end

    task automatic goto(input int n);
        int guard;
        guard = 0;
        while (cyc < n && guard < 2000) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (cyc < n) begin
            nchk++;
            nfail++;
            $display("FAIL goto_timeout: cyc=%0d want %0d", cyc, n);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        keys = '0;
        #2;
        rst_n = 1'b0;
        #1;
        nchk++;
        if (col !== 4'b1110) begin
            nfail++; $display("FAIL rst_col: got %b want 1110", col);
        end
        nchk++;
        if (dec !== 4'h0) begin
            nfail++; $display("FAIL rst_dec: got %h want 0", dec);
        end
        nchk++;
        if (bp !== 1'b0) begin
            nfail++; $display("FAIL rst_bp: got %b want 0", bp);
        end
        nchk++;
        if (ks !== 1'b0) begin
            nfail++; $display("FAIL rst_ks: got %b want 0", ks);
        end
    endtask

    task automatic test_hold5();
        keys = '0;
        keys[1][1] = 1'b1;
        do_reset();
        s0 = strobes;
        nchk++;
        if (col !== 4'b1110) begin
            nfail++; $display("FAIL col0: got %b want 1110", col);
        end
        goto(4);
        nchk++;
        if (col !== 4'b1101) begin
            nfail++; $display("FAIL col1: got %b want 1101", col);
        end
        goto(8);
        nchk++;
        if (col !== 4'b1011) begin
            nfail++; $display("FAIL col2: got %b want 1011", col);
        end
        goto(12);
        nchk++;
        if (col !== 4'b0111) begin
            nfail++; $display("FAIL col3: got %b want 0111", col);
        end
        goto(16);
        nchk++;
        if (col !== 4'b1110) begin
            nfail++; $display("FAIL col_wrap: got %b want 1110", col);
        end
        goto(31);
        nchk++;
        if (bp !== 1'b0 || ks !== 1'b0) begin
            nfail++; $display("FAIL hold5_early: bp=%b ks=%b want 0 0", bp, ks);
        end
        goto(32);
        nchk++;
        if (bp !== 1'b1) begin
            nfail++; $display("FAIL hold5_bp: got %b want 1", bp);
        end
        nchk++;
        if (dec !== 4'h5) begin
            nfail++; $display("FAIL hold5_dec: got %h want 5", dec);
        end
        nchk++;
        if (ks !== 1'b1) begin
            nfail++; $display("FAIL hold5_ks: got %b want 1", ks);
        end
        goto(33);
        nchk++;
        if (ks !== 1'b0 || bp !== 1'b1) begin
            nfail++; $display("FAIL hold5_ks_width: ks=%b bp=%b want 0 1", ks, bp);
        end
        goto(47);
        nchk++;
        if (strobes - s0 != 1) begin
            nfail++; $display("FAIL hold5_count: got %0d want 1", strobes - s0);
        end
    endtask

    task automatic test_release();
        goto(48);
        keys = '0;
        s0 = strobes;
        goto(79);
        nchk++;
        if (bp !== 1'b1) begin
            nfail++; $display("FAIL rel_early: got %b want 1", bp);
        end
        goto(80);
        nchk++;
        if (bp !== 1'b0) begin
            nfail++; $display("FAIL rel_bp: got %b want 0", bp);
        end
        nchk++;
        if (dec !== 4'h5) begin
            nfail++; $display("FAIL rel_dec: got %h want 5", dec);
        end
        goto(96);
        nchk++;
        if (strobes != s0) begin
            nfail++; $display("FAIL rel_strobe: got %0d want 0", strobes - s0);
        end
    endtask

    task automatic test_bounce();
        keys = '0;
        do_reset();
        s0 = strobes;
        goto(16);
        keys[1][1] = 1'b1;
        goto(32);
        keys = '0;
        goto(96);
        nchk++;
        if (bp !== 1'b0) begin
            nfail++; $display("FAIL bounce_bp: got %b want 0", bp);
        end
        nchk++;
        if (dec !== 4'h0) begin
            nfail++; $display("FAIL bounce_dec: got %h want 0", dec);
        end
        nchk++;
        if (strobes != s0) begin
            nfail++; $display("FAIL bounce_strobe: got %0d want 0", strobes - s0);
        end
    endtask

    task automatic test_two_keys();
        keys = '0;
        keys[0][3] = 1'b1;
        keys[1][0] = 1'b1;
        do_reset();
        s0 = strobes;
        goto(32);
        nchk++;
        if (bp !== 1'b1 || ks !== 1'b1) begin
            nfail++; $display("FAIL two_commit: bp=%b ks=%b want 1 1", bp, ks);
        end
        nchk++;
        if (dec !== 4'h4) begin
            nfail++; $display("FAIL two_dec: got %h want 4", dec);
        end
        goto(48);
        keys[0][3] = 1'b0;
        goto(112);
        nchk++;
        if (bp !== 1'b1 || dec !== 4'h4) begin
            nfail++; $display("FAIL two_hold: bp=%b dec=%h want 1 4", bp, dec);
        end
        nchk++;
        if (strobes - s0 != 1) begin
            nfail++; $display("FAIL two_count: got %0d want 1", strobes - s0);
        end
    endtask

    task automatic test_change();
        keys = '0;
        keys[1][1] = 1'b1;
        do_reset();
        s0 = strobes;
        goto(48);
        keys = '0;
        keys[3][3] = 1'b1;
        goto(96);
        nchk++;
        if (dec !== 4'h5 || bp !== 1'b1) begin
            nfail++; $display("FAIL chg_ignore: dec=%h bp=%b want 5 1", dec, bp);
        end
        nchk++;
        if (strobes - s0 != 1) begin
            nfail++; $display("FAIL chg_count1: got %0d want 1", strobes - s0);
        end
        keys = '0;
        goto(127);
        nchk++;
        if (bp !== 1'b1) begin
            nfail++; $display("FAIL chg_rel_early: got %b want 1", bp);
        end
        goto(128);
        nchk++;
        if (bp !== 1'b0) begin
            nfail++; $display("FAIL chg_rel: got %b want 0", bp);
        end
        keys[3][3] = 1'b1;
        goto(159);
        nchk++;
        if (bp !== 1'b0 || ks !== 1'b0) begin
            nfail++; $display("FAIL chg_d_early: bp=%b ks=%b want 0 0", bp, ks);
        end
        goto(160);
        nchk++;
        if (bp !== 1'b1 || ks !== 1'b1) begin
            nfail++; $display("FAIL chg_d_commit: bp=%b ks=%b want 1 1", bp, ks);
        end
        nchk++;
        if (dec !== 4'hD) begin
            nfail++; $display("FAIL chg_d_dec: got %h want d", dec);
        end
        goto(176);
        nchk++;
        if (strobes - s0 != 2) begin
            nfail++; $display("FAIL chg_count2: got %0d want 2", strobes - s0);
        end
    endtask

    task automatic test_reset_mid();
        keys = '0;
        keys[1][1] = 1'b1;
        do_reset();
        goto(40);
        nchk++;
        if (bp !== 1'b1 || col !== 4'b1011) begin
            nfail++; $display("FAIL mid_pre: bp=%b col=%b want 1 1011", bp, col);
        end
        #2;
        rst_n = 1'b0;
        #1;
        nchk++;
        if (col !== 4'b1110 || dec !== 4'h0) begin
            nfail++; $display("FAIL mid_rst_cd: col=%b dec=%h want 1110 0", col, dec);
        end
        nchk++;
        if (bp !== 1'b0 || ks !== 1'b0) begin
            nfail++; $display("FAIL mid_rst_flags: bp=%b ks=%b want 0 0", bp, ks);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        s0 = strobes;
        goto(31);
        nchk++;
        if (bp !== 1'b0) begin
            nfail++; $display("FAIL mid_early: got %b want 0", bp);
        end
        goto(32);
        nchk++;
        if (bp !== 1'b1 || ks !== 1'b1 || dec !== 4'h5) begin
            nfail++;
            $display("FAIL mid_recommit: bp=%b ks=%b dec=%h want 1 1 5", bp, ks, dec);
        end
        goto(40);
        nchk++;
        if (strobes - s0 != 1) begin
            nfail++; $display("FAIL mid_count: got %0d want 1", strobes - s0);
        end
    endtask

    initial begin
        keys = '0;
        test_reset();
        test_hold5();
        test_release();
        test_bounce();
        test_two_keys();
        test_change();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nfail);
        $finish;
    end

endmodule
